// File: rtl/cond_logic_unit.sv
// Condition-logic stage: NZCV flag register, condition evaluation and commit-strobe gating.
// Optional event counters are built when COND_PERF_CNT_EN is defined.
module cond_logic_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             CntClr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] InstrCnt,
  output logic [CNT_W-1:0] SquashCnt,
  output logic [CNT_W-1:0] BranchCnt
);

  localparam int unsigned FLAG_W = 4;

  logic [FLAG_W-1:0] flags_q;
  logic              cond_ex;
  logic              commit;
  logic              n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition evaluation always uses the architectural (registered) flags.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign commit   = Valid & cond_ex;
  assign CondEx   = cond_ex;
  assign PCSrc    = commit & PCS;
  assign RegWrite = commit & RegW & ~NoWrite;
  assign MemWrite = commit & MemW;
  assign Flags    = flags_q;

  // N,Z and C,V halves are written independently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (commit) begin
      if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] squash_cnt_q;
  logic [CNT_W-1:0] branch_cnt_q;

  // Clear wins over a same-cycle increment; all counters wrap modulo 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_cnt_q  <= '0;
      squash_cnt_q <= '0;
      branch_cnt_q <= '0;
    end else if (CntClr) begin
      instr_cnt_q  <= '0;
      squash_cnt_q <= '0;
      branch_cnt_q <= '0;
    end else begin
      if (Valid)            instr_cnt_q  <= instr_cnt_q + CNT_W'(1);
      if (Valid & ~cond_ex) squash_cnt_q <= squash_cnt_q + CNT_W'(1);
      if (PCSrc)            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
    end
  end

  assign InstrCnt  = instr_cnt_q;
  assign SquashCnt = squash_cnt_q;
  assign BranchCnt = branch_cnt_q;
`else
  logic unused_cntclr;
  assign unused_cntclr = CntClr;

  assign InstrCnt  = '0;
  assign SquashCnt = '0;
  assign BranchCnt = '0;
`endif

endmodule

// File: tb/tb_cond_logic_unit.sv
// Directed bench for cond_logic_unit; counter expectations follow COND_PERF_CNT_EN.
module tb_cond_logic_unit;

  localparam int unsigned CNT_W = 4;
`ifdef COND_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             Valid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS, RegW, MemW, NoWrite, CntClr;
  logic             PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] InstrCnt, SquashCnt, BranchCnt;

  int total = 0;
  int bad   = 0;

  cond_logic_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .CntClr(CntClr), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .Flags(Flags), .InstrCnt(InstrCnt), .SquashCnt(SquashCnt),
    .BranchCnt(BranchCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int v);
    return PERF ? 32'(v % 16) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic counters(input string tag, input int i, input int s, input int b);
    chk({tag, ".instr"},  32'(InstrCnt),  cnt(i));
    chk({tag, ".squash"}, 32'(SquashCnt), cnt(s));
    chk({tag, ".branch"}, 32'(BranchCnt), cnt(b));
  endtask

  initial begin
    logic [15:0] pass_c;
    reset = 1'b0; Valid = 1'b0; Cond = 4'b0; ALUFlags = 4'b0; FlagW = 2'b0;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; CntClr = 1'b0;
    #12;
    chk("rst.flags", 32'(Flags), 32'h0);
    counters("rst", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // EQ fails, NE passes on reset flags
    Valid = 1'b1; Cond = 4'b0000; PCS = 1'b1; #1;
    chk("eq.condex", 32'(CondEx), 32'd0);
    chk("eq.pcsrc", 32'(PCSrc), 32'd0);
    step();
    Cond = 4'b0001; #1;
    chk("ne.pcsrc", 32'(PCSrc), 32'd1);
    step();
    counters("eqne", 2, 1, 1);

    // SUBS equal sets Z, then EQ passes
    PCS = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    step();
    chk("subs.flags", 32'(Flags), 32'h4);
    Cond = 4'b0000; FlagW = 2'b00; RegW = 1'b1; #1;
    chk("eq.regwrite", 32'(RegWrite), 32'd1);
    step();

    // set Flags=1000, then GE squashes its flag write
    RegW = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1000;
    step();
    chk("n.flags", 32'(Flags), 32'h8);
    Cond = 4'b1010; ALUFlags = 4'b0001; #1;
    chk("ge.condex", 32'(CondEx), 32'd0);
    step();
    chk("ge.flags_hold", 32'(Flags), 32'h8);

    // NZ-only write: C,V hold
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b0111;
    step();
    chk("nz_only.flags", 32'(Flags), 32'h4);

    // CMP: flags written, no register write
    RegW = 1'b1; NoWrite = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0010; #1;
    chk("cmp.regwrite", 32'(RegWrite), 32'd0);
    chk("cmp.condex", 32'(CondEx), 32'd1);
    step();
    chk("cmp.flags", 32'(Flags), 32'h2);
    counters("cmp", 8, 2, 1);

    // bubble: no strobes, no state change
    Valid = 1'b0; ALUFlags = 4'b1101; PCS = 1'b1; MemW = 1'b1; #1;
    chk("bubble.pcsrc", 32'(PCSrc), 32'd0);
    chk("bubble.memwrite", 32'(MemWrite), 32'd0);
    step();
    chk("bubble.flags", 32'(Flags), 32'h2);
    counters("bubble", 8, 2, 1);

    // full condition table on Flags=0010 (only C set)
    pass_c = 16'b0101_0101_1010_0110;
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i); #1;
      chk($sformatf("cond%0d", i), 32'(CondEx), 32'(pass_c[i]));
    end

    // unsupported 1111 squashes a store
    Valid = 1'b1; Cond = 4'b1111; PCS = 1'b0; RegW = 1'b0; NoWrite = 1'b0;
    FlagW = 2'b00; MemW = 1'b1; #1;
    chk("nv.memwrite", 32'(MemWrite), 32'd0);
    step();
    counters("nv", 9, 3, 1);

    // run InstrCnt to all-ones then wrap
    repeat (6) step();
    chk("wrap.pre", 32'(InstrCnt), cnt(15));
    step();
    counters("wrap", 16, 10, 1);

    // clear has priority over increment
    MemW = 1'b0; Cond = 4'b1110; PCS = 1'b1; CntClr = 1'b1;
    step();
    counters("clr", 0, 0, 0);
    CntClr = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1111;
    step();
    chk("all.flags", 32'(Flags), 32'hf);
    counters("postclr", 1, 0, 1);

    // asynchronous reset mid-cycle
    Valid = 1'b0; PCS = 1'b0; FlagW = 2'b00; Cond = 4'b1000;
    #2 reset = 1'b0; #1;
    chk("async.flags", 32'(Flags), 32'h0);
    counters("async", 0, 0, 0);
    chk("async.hi", 32'(CondEx), 32'd0);
    Cond = 4'b0001; #1;
    chk("async.ne", 32'(CondEx), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    Valid = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110;
    step();
    chk("post_rst.flags", 32'(Flags), 32'h6);
    counters("post_rst", 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_logic_unit.md
# cond_logic_unit

Condition-logic stage of the single-cycle ARM controller, directly downstream of the instruction decoder. Holds the architectural NZCV flag register, evaluates the instruction's 4-bit condition field against it, and gates the decoder's raw write/branch requests (PCS, RegW, MemW, NoWrite, FlagW) into the committed PCSrc, RegWrite and MemWrite strobes. Optional retire/squash/branch event counters support bring-up and CPI measurement.

## Interface
Parameters:
- CNT_W, 32, width of each event counter; counters only exist with COND_PERF_CNT_EN.

Ports:
- clk  in  1  processor clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- Valid  in  1  an instruction executes this cycle; 0 = bubble, no side effects
- Cond  in  4  Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle
- FlagW  in  2  decoder flag-write request: [1]=N,Z; [0]=C,V
- PCS, RegW, MemW, NoWrite  in  1 each  decoder requests
- CntClr  in  1  synchronous clear of all event counters
- PCSrc, RegWrite, MemWrite  out  1 each  gated commit strobes
- CondEx  out  1  condition passed
- Flags  out  4  registered {N,Z,C,V}
- InstrCnt, SquashCnt, BranchCnt  out  CNT_W each  event counters

## Operation
- CondEx from registered Flags (never ALUFlags): EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1; 1111 -> 0 (unsupported, squashed).
- PCSrc = Valid & CondEx & PCS.
- RegWrite = Valid & CondEx & RegW & !NoWrite.
- MemWrite = Valid & CondEx & MemW.
- Flag write: Flags[3:2] <= ALUFlags[3:2] when Valid & CondEx & FlagW[1]; Flags[1:0] <= ALUFlags[1:0] when Valid & CondEx & FlagW[0]; halves independent, otherwise hold.
- Squashed instruction (CondEx=0): no register, memory, PC or flag effect.
- Counters (COND_PERF_CNT_EN): InstrCnt +1 per Valid cycle; SquashCnt +1 when Valid & !CondEx; BranchCnt +1 when PCSrc=1. Modulo 2^CNT_W, all-ones wraps to 0. CntClr has priority over same-cycle increment (result 0).

## Timing
- Cond/flags -> PCSrc, RegWrite, MemWrite, CondEx: combinational, same cycle.
- Flags: 1-cycle latency; instruction N's flag write is visible to instruction N+1's condition.
- Counters: value reflects events up to and including previous cycle.
- Reset (any time, including mid-instruction): Flags=0000, counters=0 immediately and asynchronously; combinational outputs then follow Flags=0000 (e.g. EQ fails, NE passes). First edge after deassertion updates normally.
- Valid=0: all strobes 0, Flags and counters hold regardless of other inputs.

## Configuration
- COND_PERF_CNT_EN defined: three CNT_W-bit counters and CntClr logic present as described.
- Undefined: no counter registers; InstrCnt, SquashCnt, BranchCnt driven constant 0; CntClr ignored; all other behaviour identical.

## Test plan
- Reset, Cond=0000 (EQ), PCS=1, Valid=1 -> PCSrc=0, CondEx=0; Cond=0001 (NE) -> PCSrc=1; with counters, SquashCnt=1 and BranchCnt=1 after two edges.
- Cond=1110, FlagW=11, ALUFlags=0100 (SUBS equal) -> next cycle Flags=0100; Cond=0000, RegW=1 -> RegWrite=1.
- Flags=1000, Cond=1010 (GE), FlagW=11, ALUFlags=0001 -> CondEx=0, Flags stay 1000 (squashed flag write); FlagW=10 with Cond=1110, ALUFlags=0111 -> Flags=0100, C,V hold 00.
- CMP: Cond=1110, RegW=1, NoWrite=1, FlagW=11 -> RegWrite=0, flags updated next cycle; Valid=0 same inputs -> no flag change, InstrCnt unchanged.
- Cond=1111, MemW=1 -> MemWrite=0, SquashCnt +1; preload counters near all-ones (run 2^CNT_W-1 cycles with CNT_W reduced to 4) -> wrap to 0; CntClr with Valid=1 -> InstrCnt=0.
- Assert reset mid-cycle with Flags=1111 and counters nonzero -> Flags and counters 0 before next edge; Cond=1000 (HI) -> CondEx=0 during reset.
